// File: rtl/writeback_logic_gen.sv
// -----------------------------------------------------------------------------
// writeback_logic_gen
//   Write-side counterpart of the tile fetch logic. Accepts result words over a
//   valid/ready handshake and drives BRAM port A (ena/wea/addra/dina). Each tile
//   is NUM_WRITES_PER_TILE words written to base + idx*ADDR_STRIDE. The tile
//   base advances by one tile span after every completed tile.
//
// Ports
//   clk                 in   system clock, rising edge
//   rst                 in   synchronous active-high reset
//   start_write         in   arm one tile write (sampled in IDLE only)
//   reset_addr_counter  in   reload tile base with WRITE_START_OFFSET (IDLE/DONE)
//   in_valid / in_data  in   result word handshake (valid side)
//   in_ready            out  high while a tile is being written
//   bram_en / bram_we   out  port A enable / write enable
//   bram_addr           out  port A address
//   bram_din            out  port A write data
//   busy                out  tile in progress
//   write_done          out  one-cycle pulse; coincides with the last word on port A
// -----------------------------------------------------------------------------
module writeback_logic_gen #(
   parameter int unsigned NUM_WRITES_PER_TILE = 32,
   parameter int unsigned ADDR_WIDTH          = 16,
   parameter int unsigned WRITE_START_OFFSET  = 0,
   parameter int unsigned ADDR_STRIDE         = 1,
   parameter int unsigned DATA_WIDTH          = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_write,
   input  logic                  reset_addr_counter,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  bram_en,
   output logic                  bram_we,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [DATA_WIDTH-1:0] bram_din,
   output logic                  busy,
   output logic                  write_done
);

   localparam int unsigned IDX_W = $clog2(NUM_WRITES_PER_TILE + 1);
   localparam int unsigned SPAN  = NUM_WRITES_PER_TILE * ADDR_STRIDE;
   // Guard bits so the strided offset and tile span never overflow before truncation.
   localparam int unsigned GW    = ADDR_WIDTH + $clog2(SPAN + 1);

   localparam logic [GW-1:0]         STRIDE_G = GW'(ADDR_STRIDE);
   localparam logic [GW-1:0]         SPAN_G   = GW'(SPAN);
   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_WRITES_PER_TILE - 1);
   localparam logic [ADDR_WIDTH-1:0] OFFSET   = ADDR_WIDTH'(WRITE_START_OFFSET);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [IDX_W-1:0]      r_idx;
   logic [ADDR_WIDTH-1:0] r_base;
   logic                  r_en;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_din;

   logic                  w_ready;
   logic                  w_accept;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [ADDR_WIDTH-1:0] w_next_base;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // Next state and state-decoded outputs
   always_comb begin
      w_state_next = r_state;
      w_ready      = 1'b0;
      busy         = 1'b0;
      write_done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_write) w_state_next = S_WRITE;
         end
         S_WRITE: begin
            w_ready = 1'b1;
            busy    = 1'b1;
            if (in_valid && (r_idx == LAST_IDX)) w_state_next = S_DONE;
         end
         S_DONE: begin
            busy         = 1'b1;
            write_done   = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign in_ready = w_ready;
   assign w_accept = in_valid & w_ready;

   // Address arithmetic in guard width; the wrap to ADDR_WIDTH is silent.
   always_comb begin
      w_addr      = ADDR_WIDTH'(GW'(r_base) + GW'(r_idx) * STRIDE_G);
      w_next_base = ADDR_WIDTH'(GW'(r_base) + SPAN_G);
   end

   // Port A registers, word index and tile base
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx  <= '0;
         r_base <= OFFSET;
         r_en   <= 1'b0;
         r_addr <= '0;
         r_din  <= '0;
      end else begin
         r_en <= w_accept;
         if (w_accept) begin
            r_addr <= w_addr;
            r_din  <= in_data;
            r_idx  <= r_idx + IDX_W'(1);
         end
         case (r_state)
            S_IDLE: begin
               if (reset_addr_counter) r_base <= OFFSET;
            end
            S_DONE: begin
               r_idx  <= '0;
               r_base <= reset_addr_counter ? OFFSET : w_next_base;
            end
            default: ;
         endcase
      end
   end

   assign bram_en   = r_en;
   assign bram_we   = r_en;
   assign bram_addr = r_addr;
   assign bram_din  = r_din;

endmodule

// File: tb/tb_writeback_logic_gen.sv
// -----------------------------------------------------------------------------
// tb_writeback_logic_gen
//   Directed bench for writeback_logic_gen. Three instances:
//     A: defaults (32 words, stride 1, 16-bit addr, 256-bit data)
//     B: 4 words, stride 24, handshake bubbles
//     C: 6-bit address, start offset 60, 8 words (address wrap)
// -----------------------------------------------------------------------------
module tb_writeback_logic_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // ---------------- instance A ----------------
   logic         a_rst = 1'b1, a_start = 1'b0, a_rac = 1'b0, a_valid = 1'b0;
   logic [255:0] a_data = '0;
   logic         a_ready, a_en, a_we, a_busy, a_done;
   logic [15:0]  a_addr;
   logic [255:0] a_din;

   writeback_logic_gen u_a (
      .clk(clk), .rst(a_rst), .start_write(a_start), .reset_addr_counter(a_rac),
      .in_valid(a_valid), .in_data(a_data), .in_ready(a_ready),
      .bram_en(a_en), .bram_we(a_we), .bram_addr(a_addr), .bram_din(a_din),
      .busy(a_busy), .write_done(a_done)
   );

   // ---------------- instance B ----------------
   logic        bc_rst = 1'b1;
   logic        b_start = 1'b0, b_rac = 1'b0, b_valid = 1'b0;
   logic [15:0] b_data = '0;
   logic        b_ready, b_en, b_we, b_busy, b_done;
   logic [15:0] b_addr;
   logic [15:0] b_din;

   writeback_logic_gen #(
      .NUM_WRITES_PER_TILE(4), .ADDR_WIDTH(16), .WRITE_START_OFFSET(0),
      .ADDR_STRIDE(24), .DATA_WIDTH(16)
   ) u_b (
      .clk(clk), .rst(bc_rst), .start_write(b_start), .reset_addr_counter(b_rac),
      .in_valid(b_valid), .in_data(b_data), .in_ready(b_ready),
      .bram_en(b_en), .bram_we(b_we), .bram_addr(b_addr), .bram_din(b_din),
      .busy(b_busy), .write_done(b_done)
   );

   // ---------------- instance C ----------------
   logic        c_start = 1'b0, c_rac = 1'b0, c_valid = 1'b0;
   logic [15:0] c_data = '0;
   logic        c_ready, c_en, c_we, c_busy, c_done;
   logic [5:0]  c_addr;
   logic [15:0] c_din;

   writeback_logic_gen #(
      .NUM_WRITES_PER_TILE(8), .ADDR_WIDTH(6), .WRITE_START_OFFSET(60),
      .ADDR_STRIDE(1), .DATA_WIDTH(16)
   ) u_c (
      .clk(clk), .rst(bc_rst), .start_write(c_start), .reset_addr_counter(c_rac),
      .in_valid(c_valid), .in_data(c_data), .in_ready(c_ready),
      .bram_en(c_en), .bram_we(c_we), .bram_addr(c_addr), .bram_din(c_din),
      .busy(c_busy), .write_done(c_done)
   );

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] mk(input int unsigned k);
      return {8{32'hC0DE0000 ^ k}};
   endfunction

   // One full 32-word tile on instance A with back-to-back valid words.
   // poke=1 pulses start_write and reset_addr_counter mid-tile (must be ignored).
   task automatic tile_a(input int unsigned base, input int unsigned seed, input bit poke);
      int unsigned dones;
      dones   = 0;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      a_rac   = 1'b0;
      check_eq("a_ready_write", a_ready, 1);
      check_eq("a_busy_write", a_busy, 1);
      for (int unsigned k = 0; k < 32; k++) begin
         a_valid = 1'b1;
         a_data  = mk(seed + k);
         if (poke && k == 5) a_start = 1'b1;
         if (poke && k == 6) a_rac   = 1'b1;
         tick();
         a_start = 1'b0;
         a_rac   = 1'b0;
         check_eq("a_en", a_en, 1);
         check_eq("a_we", a_we, 1);
         check_eq("a_addr", a_addr, (base + k) & 32'hFFFF);
         check_eq("a_din", a_din, mk(seed + k));
         check_eq("a_done", a_done, (k == 31) ? 1 : 0);
         if (a_done) dones++;
      end
      a_valid = 1'b0;
      tick();
      check_eq("a_busy_after", a_busy, 0);
      check_eq("a_done_after", a_done, 0);
      check_eq("a_en_after", a_en, 0);
      check_eq("a_addr_hold", a_addr, (base + 31) & 32'hFFFF);
      check_eq("a_done_count", dones, 1);
   endtask

   initial begin
      int unsigned acc, dones, writes;
      int unsigned vpat [8];
      vpat = '{0, 1, 0, 0, 1, 1, 0, 1};

      repeat (2) tick();
      a_rst  = 1'b0;
      bc_rst = 1'b0;

      // Reset state
      check_eq("rst_ready", a_ready, 0);
      check_eq("rst_en", a_en, 0);
      check_eq("rst_we", a_we, 0);
      check_eq("rst_busy", a_busy, 0);
      check_eq("rst_done", a_done, 0);
      check_eq("rst_addr", a_addr, 0);
      check_eq("rst_din", a_din, 0);

      // 1/2: consecutive tiles advance base; reset_addr_counter with start restarts at 0
      tile_a(0, 100, 1'b0);
      tile_a(32, 200, 1'b0);
      a_rac = 1'b1;
      tile_a(0, 300, 1'b0);

      // 5: reset after 10 accepts (base is now 32)
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      for (int unsigned k = 0; k < 10; k++) begin
         a_valid = 1'b1;
         a_data  = mk(400 + k);
         tick();
      end
      check_eq("pre_rst_addr", a_addr, 32 + 9);
      a_rst = 1'b1;
      tick();
      a_rst   = 1'b0;
      a_valid = 1'b0;
      check_eq("mid_rst_ready", a_ready, 0);
      check_eq("mid_rst_en", a_en, 0);
      check_eq("mid_rst_we", a_we, 0);
      check_eq("mid_rst_busy", a_busy, 0);
      check_eq("mid_rst_done", a_done, 0);
      check_eq("mid_rst_addr", a_addr, 0);
      check_eq("mid_rst_din", a_din, 0);
      tick();
      check_eq("post_rst_done", a_done, 0);
      tile_a(0, 500, 1'b0);

      // 6: start/reset_addr_counter during WRITE ignored; base then advances to 64
      tile_a(32, 600, 1'b1);
      tile_a(64, 700, 1'b0);

      // 3: stride 24, 4 words, bubbles
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      acc = 0; dones = 0; writes = 0;
      for (int unsigned i = 0; i < 8; i++) begin
         b_valid = vpat[i][0];
         b_data  = 16'(16'h0100 + i);
         tick();
         if (b_done) dones++;
         if (b_we) writes++;
         if (vpat[i] != 0) begin
            check_eq("b_we_beat", b_we, 1);
            check_eq("b_addr_beat", b_addr, acc * 24);
            check_eq("b_din_beat", b_din, 16'h0100 + i);
            acc++;
            check_eq("b_done_beat", b_done, (acc == 4) ? 1 : 0);
         end else begin
            check_eq("b_we_bubble", b_we, 0);
            check_eq("b_en_bubble", b_en, 0);
         end
      end
      // Keep offering data after the tile: nothing more may be written
      b_valid = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         tick();
         if (b_done) dones++;
         if (b_we) writes++;
      end
      b_valid = 1'b0;
      check_eq("b_busy_end", b_busy, 0);
      check_eq("b_write_count", writes, 4);
      check_eq("b_done_count", dones, 1);

      // 4: 6-bit address wrap from offset 60, then next base 4
      for (int unsigned t = 0; t < 2; t++) begin
         c_start = 1'b1;
         tick();
         c_start = 1'b0;
         for (int unsigned k = 0; k < 8; k++) begin
            c_valid = 1'b1;
            c_data  = 16'(16'h0C00 + 16 * t + k);
            tick();
            check_eq("c_we", c_we, 1);
            check_eq("c_addr", c_addr, (((t == 0) ? 60 : 4) + k) % 64);
            check_eq("c_din", c_din, 16'h0C00 + 16 * t + k);
            check_eq("c_done", c_done, (k == 7) ? 1 : 0);
         end
         c_valid = 1'b0;
         tick();
         check_eq("c_busy_after", c_busy, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached, expected completion");
      $fatal(1);
   end

endmodule
